// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory line port between icache fills, dcache fills and dcache
// evictions. One transaction at a time, fixed D-write > D-read > I-read priority with I starvation guard.
module mem_arbiter #(
  parameter int unsigned ARCH_BITS    = 32,
  parameter int unsigned LINE_BITS    = 128,
  parameter int unsigned OFFSET_BITS  = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iReadReq,
  input  logic [ARCH_BITS-1:0] iReadAddr,
  output logic [LINE_BITS-1:0] iReadData,
  output logic                 iReadValid,
  input  logic                 dReadReq,
  input  logic [ARCH_BITS-1:0] dReadAddr,
  output logic [LINE_BITS-1:0] dReadData,
  output logic                 dReadValid,
  input  logic                 dWriteReq,
  input  logic [ARCH_BITS-1:0] dWriteAddr,
  input  logic [LINE_BITS-1:0] dWriteLine,
  output logic                 dWriteAck,
  output logic                 memReq,
  output logic                 memWE,
  output logic [ARCH_BITS-1:0] memAddr,
  output logic [LINE_BITS-1:0] memWLine,
  input  logic [LINE_BITS-1:0] memRLine,
  input  logic                 memAck
);

  localparam int unsigned CntBits = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntBits-1:0] StarveMax = CntBits'(STARVE_LIMIT);
  localparam logic [ARCH_BITS-1:0] OffsetMask = ARCH_BITS'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [2:0] {StIdle, StDWr, StDRd, StIRd, StResp} stateT;
  typedef enum logic [1:0] {OwnI, OwnDRd, OwnDWr} ownerT;

  stateT                stateQ, stateD;
  ownerT                ownerQ, ownerD;
  logic [CntBits-1:0]   starveQ, starveD;
  logic                 okQ, okD;
  logic [ARCH_BITS-1:0] addrQ, addrD;
  logic [LINE_BITS-1:0] wLineQ, wLineD;
  logic [LINE_BITS-1:0] iDataQ, iDataD;
  logic [LINE_BITS-1:0] dDataQ, dDataD;
  logic                 ownerReq;
  logic                 grant;
  logic [ARCH_BITS-1:0] selAddr;

  always_comb begin
    stateD   = stateQ;
    ownerD   = ownerQ;
    starveD  = starveQ;
    okD      = okQ;
    addrD    = addrQ;
    wLineD   = wLineQ;
    iDataD   = iDataQ;
    dDataD   = dDataQ;
    grant    = 1'b0;
    selAddr  = iReadAddr;
    ownerReq = 1'b0;

    unique case (ownerQ)
      OwnI:    ownerReq = iReadReq;
      OwnDRd:  ownerReq = dReadReq;
      OwnDWr:  ownerReq = dWriteReq;
      default: ownerReq = 1'b0;
    endcase

    unique case (stateQ)
      StIdle: begin
        grant = 1'b1;
        if (starveQ == StarveMax && iReadReq) begin
          ownerD = OwnI;
        end else if (dWriteReq) begin
          ownerD = OwnDWr;
        end else if (dReadReq) begin
          ownerD = OwnDRd;
        end else if (iReadReq) begin
          ownerD = OwnI;
        end else begin
          grant = 1'b0;
        end
        if (grant) begin
          unique case (ownerD)
            OwnDWr: begin
              stateD  = StDWr;
              selAddr = dWriteAddr;
              wLineD  = dWriteLine;
            end
            OwnDRd: begin
              stateD  = StDRd;
              selAddr = dReadAddr;
            end
            default: begin
              stateD  = StIRd;
              selAddr = iReadAddr;
            end
          endcase
          addrD = selAddr & ~OffsetMask;
          // Any grant without a waiting I-side, or an I grant, resets the guard.
          if (ownerD == OwnI || !iReadReq) begin
            starveD = '0;
          end else if (starveQ != StarveMax) begin
            starveD = starveQ + CntBits'(1);
          end
        end
      end
      StDWr, StDRd, StIRd: begin
        if (memAck) begin
          // A requester that dropped its level has abandoned the transaction.
          okD = ownerReq;
          if (ownerReq && stateQ == StIRd) iDataD = memRLine;
          if (ownerReq && stateQ == StDRd) dDataD = memRLine;
          stateD = StResp;
        end
      end
      StResp:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= StIdle;
      ownerQ  <= OwnI;
      starveQ <= '0;
      okQ     <= 1'b0;
      addrQ   <= '0;
      wLineQ  <= '0;
      iDataQ  <= '0;
      dDataQ  <= '0;
    end else begin
      stateQ  <= stateD;
      ownerQ  <= ownerD;
      starveQ <= starveD;
      okQ     <= okD;
      addrQ   <= addrD;
      wLineQ  <= wLineD;
      iDataQ  <= iDataD;
      dDataQ  <= dDataD;
    end
  end

  assign memReq     = (stateQ == StDWr) || (stateQ == StDRd) || (stateQ == StIRd);
  assign memWE      = (stateQ == StDWr);
  assign memAddr    = addrQ;
  assign memWLine   = wLineQ;
  assign iReadData  = iDataQ;
  assign dReadData  = dDataQ;
  assign iReadValid = (stateQ == StResp) && okQ && (ownerQ == OwnI);
  assign dReadValid = (stateQ == StResp) && okQ && (ownerQ == OwnDRd);
  assign dWriteAck  = (stateQ == StResp) && okQ && (ownerQ == OwnDWr);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic iReadReq, dReadReq, dWriteReq;
  logic [31:0] iReadAddr, dReadAddr, dWriteAddr;
  logic [127:0] dWriteLine, memRLine;
  logic memAck;
  logic [127:0] iReadData, dReadData, memWLine;
  logic iReadValid, dReadValid, dWriteAck, memReq, memWE;
  logic [31:0] memAddr;

  mem_arbiter #(.ARCH_BITS(32), .LINE_BITS(128), .OFFSET_BITS(4), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .iReadReq(iReadReq), .iReadAddr(iReadAddr), .iReadData(iReadData), .iReadValid(iReadValid),
    .dReadReq(dReadReq), .dReadAddr(dReadAddr), .dReadData(dReadData), .dReadValid(dReadValid),
    .dWriteReq(dWriteReq), .dWriteAddr(dWriteAddr), .dWriteLine(dWriteLine),
    .dWriteAck(dWriteAck), .memReq(memReq), .memWE(memWE), .memAddr(memAddr),
    .memWLine(memWLine), .memRLine(memRLine), .memAck(memAck)
  );

  always #5 clk = ~clk;

  // Memory responder controls
  int memLat = 1;
  int forceReq = 0;
  bit spurious = 1'b0;
  bit randLine = 1'b0;
  logic [127:0] memPattern = '0;

  initial begin
    int waitCnt;
    int seen;
    waitCnt = 0;
    seen = 0;
    memAck = 1'b0;
    memRLine = '0;
    forever begin
      @(negedge clk);
      memAck = 1'b0;
      if (forceReq != seen) begin
        seen = forceReq;
        memAck = 1'b1;
        memRLine = {4{$urandom}};
      end else if (memReq === 1'b1) begin
        if (waitCnt >= memLat) begin
          memAck = 1'b1;
          memRLine = randLine ? {$urandom, $urandom, $urandom, $urandom} : memPattern;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
        if (spurious && $urandom_range(0, 7) == 0) begin
          memAck = 1'b1;
          memRLine = {4{$urandom}};
        end
      end
    end
  end

  // Transaction-level model: owner 0 = I read, 1 = D read, 2 = D write
  bit mBusy, mResp, mOk;
  int mOwner, mStarve;
  logic [31:0] mAddr;
  logic [127:0] mWLine, mIData, mDData;
  int grantLog[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    int w;
    bit req;
    logic [31:0] a;
    if (rst) begin
      mBusy = 0; mResp = 0; mOk = 0; mOwner = 0; mStarve = 0;
      mAddr = '0; mWLine = '0; mIData = '0; mDData = '0;
    end else if (mResp) begin
      mResp = 0;
    end else if (mBusy) begin
      if (memAck) begin
        req = (mOwner == 0) ? iReadReq : (mOwner == 1) ? dReadReq : dWriteReq;
        mOk = req;
        if (req && mOwner == 0) mIData = memRLine;
        if (req && mOwner == 1) mDData = memRLine;
        mBusy = 0;
        mResp = 1;
      end
    end else begin
      w = -1;
      if (mStarve == LIMIT && iReadReq) w = 0;
      else if (dWriteReq) w = 2;
      else if (dReadReq) w = 1;
      else if (iReadReq) w = 0;
      if (w >= 0) begin
        mBusy = 1;
        mOwner = w;
        a = (w == 2) ? dWriteAddr : (w == 1) ? dReadAddr : iReadAddr;
        mAddr = a - (a % 32'd16);
        if (w == 2) mWLine = dWriteLine;
        if (w != 0 && iReadReq) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
        else mStarve = 0;
        grantLog.push_back(w);
      end
    end
  endtask

  task automatic compareAll();
    chk("memReq", memReq, mBusy);
    chk("memWE", memWE, mBusy && mOwner == 2);
    chk("memAddr", memAddr, mAddr);
    chk("memWLine", memWLine, mWLine);
    chk("iReadValid", iReadValid, mResp && mOk && mOwner == 0);
    chk("dReadValid", dReadValid, mResp && mOk && mOwner == 1);
    chk("dWriteAck", dWriteAck, mResp && mOk && mOwner == 2);
    chk("iReadData", iReadData, mIData);
    chk("dReadData", dReadData, mDData);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  function automatic logic getSig(input int which);
    case (which)
      0: return iReadValid;
      1: return dReadValid;
      2: return dWriteAck;
      default: return memReq;
    endcase
  endfunction

  task automatic waitOut(input int which, input string name, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n++;
      if (getSig(which) === 1'b1) return;
    end
    chk({name, " timeout"}, getSig(which), 1);
  endtask

  initial begin
    int n;
    int strobes[$];
    logic opWe[$];
    logic [31:0] opAddr[$];
    logic [127:0] opLine[$];
    logic prevReq;
    int expSeq[10];

    // 1. reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iReadReq = 1'($urandom); dReadReq = 1'($urandom); dWriteReq = 1'($urandom);
      iReadAddr = $urandom; dReadAddr = $urandom; dWriteAddr = $urandom;
      dWriteLine = {4{$urandom}};
      cycle();
    end
    chk("rst memReq", memReq, 0);
    chk("rst memAddr", memAddr, 0);
    chk("rst iReadData", iReadData, 0);
    rst = 1'b0;
    iReadReq = 0; dReadReq = 0; dWriteReq = 0;
    forceReq++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("idle ack strobes", {iReadValid, dReadValid, dWriteAck}, 0);
    end

    // 2. single icache fill
    iReadReq = 1; iReadAddr = 32'h0000_123C;
    memLat = 3; memPattern = {16{8'hA5}};
    waitOut(3, "t2 memReq", n);
    chk("t2 memAddr", memAddr, 32'h0000_1230);
    chk("t2 memWE", memWE, 0);
    waitOut(0, "t2 iReadValid", n);
    chk("t2 latency", n, 4);
    chk("t2 iReadData", iReadData, {16{8'hA5}});
    iReadReq = 0;
    cycle();
    chk("t2 single pulse", iReadValid, 0);

    // 3. all three requesters at once
    memLat = 1;
    dWriteReq = 1; dReadReq = 1; iReadReq = 1;
    dWriteAddr = 32'h0000_2004; dReadAddr = 32'h0000_3008; iReadAddr = 32'h0000_400C;
    dWriteLine = {8{16'hBEEF}}; memPattern = {16{8'h77}};
    prevReq = 0;
    for (int i = 0; i < 60 && strobes.size() < 3; i++) begin
      cycle();
      if (memReq && !prevReq) begin
        opWe.push_back(memWE); opAddr.push_back(memAddr); opLine.push_back(memWLine);
      end
      prevReq = memReq;
      if (dWriteAck) begin strobes.push_back(2); dWriteReq = 0; end
      if (dReadValid) begin strobes.push_back(1); dReadReq = 0; end
      if (iReadValid) begin strobes.push_back(0); iReadReq = 0; end
    end
    chk("t3 strobe count", strobes.size(), 3);
    chk("t3 op count", opWe.size(), 3);
    if (strobes.size() == 3 && opWe.size() == 3) begin
      chk("t3 strobe0", strobes[0], 2);
      chk("t3 strobe1", strobes[1], 1);
      chk("t3 strobe2", strobes[2], 0);
      chk("t3 op0 we", opWe[0], 1);
      chk("t3 op0 addr", opAddr[0], 32'h0000_2000);
      chk("t3 op0 line", opLine[0], {8{16'hBEEF}});
      chk("t3 op1 we", opWe[1], 0);
      chk("t3 op1 addr", opAddr[1], 32'h0000_3000);
      chk("t3 op2 we", opWe[2], 0);
      chk("t3 op2 addr", opAddr[2], 32'h0000_4000);
    end
    cycle();

    // 4. starvation guard
    memLat = 0; memPattern = {16{8'h3C}};
    iReadAddr = 32'h0000_5000; dReadAddr = 32'h0000_6000;
    iReadReq = 1; dReadReq = 1;
    strobes.delete();
    grantLog.delete();
    for (int i = 0; i < 200 && strobes.size() < 10; i++) begin
      cycle();
      if (dReadValid) strobes.push_back(1);
      if (iReadValid) strobes.push_back(0);
      dReadReq = !dReadValid;
      iReadReq = !iReadValid;
    end
    iReadReq = 0; dReadReq = 0;
    expSeq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    chk("t4 strobe count", strobes.size(), 10);
    for (int i = 0; i < 10 && i < strobes.size(); i++) chk("t4 dut order", strobes[i], expSeq[i]);
    for (int i = 0; i < 10 && i < grantLog.size(); i++) chk("t4 model order", grantLog[i], expSeq[i]);
    cycle();
    cycle();

    // 5. icache aborts mid-transaction
    memLat = 4; memPattern = {16{8'h5A}};
    iReadReq = 1; iReadAddr = 32'h0000_7000;
    waitOut(3, "t5 memReq", n);
    iReadReq = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5 memReq held", memReq, 1);
    end
    cycle();
    chk("t5 memReq released", memReq, 0);
    chk("t5 no strobe", iReadValid, 0);
    cycle();
    chk("t5 no strobe late", iReadValid, 0);
    chk("t5 iReadData kept", iReadData, {16{8'h3C}});

    // 6. reset during an eviction
    memLat = 20;
    dWriteReq = 1; dWriteAddr = 32'h0000_8010; dWriteLine = {4{32'h1234_5678}};
    waitOut(3, "t6 memReq", n);
    chk("t6 memWE", memWE, 1);
    cycle();
    rst = 1; dWriteReq = 0;
    cycle();
    chk("t6 memReq after rst", memReq, 0);
    chk("t6 no ack", dWriteAck, 0);
    rst = 0;
    forceReq++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6 late ack ignored", {dWriteAck, memReq}, 0);
    end

    // Randomized traffic
    spurious = 1; randLine = 1;
    for (int i = 0; i < 3000; i++) begin
      memLat = $urandom_range(0, 4);
      cycle();
      rst = ($urandom_range(0, 299) == 0);
      if (iReadReq) begin
        if (iReadValid || $urandom_range(0, 63) == 0) iReadReq = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        iReadReq = 1; iReadAddr = $urandom;
      end
      if (dReadReq) begin
        if (dReadValid || $urandom_range(0, 63) == 0) dReadReq = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        dReadReq = 1; dReadAddr = $urandom;
      end
      if (dWriteReq) begin
        if (dWriteAck || $urandom_range(0, 63) == 0) dWriteReq = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        dWriteReq = 1; dWriteAddr = $urandom;
        dWriteLine = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 0) begin
          dReadReq = 1; dReadAddr = $urandom;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
